csc_rgb2ycbcr_pipe: RTL and testbench
=====================================

# csc_rgb2ycbcr_pipe

Parametrised RGB-to-YCbCr colour-space converter with a valid/ready stream interface, runtime-selectable conversion matrix, rounding and output clamping. Sits between the camera capture path and the image-processing/VDMA path, replacing the fixed 8-bit BT.601 converter. Carries vsync/href/de per beat as sideband, with a fixed latency matched to the data.

## Interface
- DW, 8: bits per colour component (8..12); input {R,G,B} and output {Y,Cb,Cr} are each DW bits.
- Reset `rst_n` is synchronous and active-low; the clock is `sys_clk`.
- sys_clk  in  1  processing clock; all logic on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- mode  in  2  0 = BT.601 full range, 1 = BT.709 full range, 2 = BT.601 limited range, 3 = bypass.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_data  in  3*DW  {R,G,B}, R in the MSBs.
- s_user  in  3  {vsync, href, de} for this beat.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- m_data  out  3*DW  {Y,Cb,Cr}, Y in the MSBs.
- m_user  out  3  s_user of the same beat, delayed with it.

## Operation
- Pipeline of 3 register stages (S1 products, S2 sum+offset+round, S3 shift+clamp = output register), each stage with its own valid bit.
- Global advance enable: en = !m_valid || m_ready. s_ready = en. When en = 0, every stage holds its data, user bits and valid bit.
- Coefficients are signed, scaled ×256:
  - Mode 0: Y = 77,150,29. Cb = -43,-85,128. Cr = 128,-107,-21.
  - Mode 1: Y = 54,183,19. Cb = -29,-99,128. Cr = 128,-116,-12.
  - Mode 2: Y = 66,129,25. Cb = -38,-74,112. Cr = 112,-94,-18.
- Offsets, added before the shift:
  - Modes 0/1: Y = 0, Cb/Cr = 128<<(DW-8), each shifted left by 8.
  - Mode 2: Y = 16<<(DW-8), Cb/Cr = 128<<(DW-8), each shifted left by 8.
- Rounding: add 128 before an arithmetic right shift by 8.
- Widths: products are DW+9 bits signed; sums are DW+11 bits signed, so no internal overflow.
- Clamp: the shifted result is clamped to [0, 2^DW-1]. Negative values give 0; values above the range give all-ones.
- Bypass (mode 3): m_data equals s_data of the same beat, at the same latency.
- Blanking: when the beat's de bit is 0, m_data = 0; m_user still passes through.
- The mode in effect for each beat travels with the beat through the pipeline, so a mode change never corrupts in-flight beats.

## Timing
- Reset values: m_valid = 0, m_data = 0, m_user = 0, all stage valid bits 0, active mode = 0. s_ready = 1 in the first cycle after reset (m_valid = 0).
- Latency: 3 sys_clk cycles from acceptance to m_valid, when m_ready is held 1. Throughput is 1 beat per clock.
- Stall:
  - With m_valid = 1 and m_ready = 0: s_ready = 0 in the same cycle (combinational), and all registers hold.
  - No beat is dropped, duplicated or reordered.
- Bubbles: when s_valid = 0, stage valid bits shift through as 0. m_valid deasserts exactly 3 cycles after the last accepted beat, when the output is not stalled.
- Reset asserted mid-stream: all in-flight beats are discarded and outputs go to their reset values on the next edge.
- m_user bits align exactly with m_data of the same beat.

## Configuration
- CSC_FRAME_LOCK_EN defined:
  - `mode` is sampled into the active-mode register only on an accepted beat whose vsync = 1 while the previous accepted beat had vsync = 0 (frame start).
  - That beat and all later beats use the new mode.
  - Mode changes mid-frame take effect at the next frame start.
- CSC_FRAME_LOCK_EN undefined: `mode` is sampled on every accepted beat.

## Test plan
- DW = 8, mode 0, white (255,255,255), m_ready = 1 -> Y = 255, Cb = 128, Cr = 128; m_valid high 3 cycles after acceptance.
- DW = 8, mode 0, red (255,0,0):
  - Y = 77, Cb = 85.
  - Raw Cr = 256, clamped to Cr = 255.
- DW = 8, mode 2:
  - Black (0,0,0) -> Y = 16, Cb = 128, Cr = 128.
  - White -> Y = 235, Cb = 128, Cr = 128.
- Mode 3, s_data = 0x123456, de = 1 -> m_data = 0x123456 after 3 cycles. Same beat with de = 0 -> m_data = 0, m_user = s_user.
- Continuous ramp input, m_ready low for 5 cycles mid-stream -> s_ready low during the stall; output sequence is identical to the no-stall reference, with no loss and in order.
- With CSC_FRAME_LOCK_EN:
  - Setup: mode switched 0 -> 1 mid-frame while white-then-red beats stream.
  - Red beats before the next vsync rise give Y = 77 (mode 0).
  - The first beat after the vsync rise gives Y = 54 (mode 1).

Source files
------------

// File: rtl/csc_rgb2ycbcr_pipe.sv
// RGB -> YCbCr converter: 3-stage valid/ready pipeline with per-beat mode, rounding and clamping.
// Define CSC_FRAME_LOCK_EN to latch `mode` only at frame start (rising vsync on an accepted beat).
module csc_rgb2ycbcr_pipe #(
  parameter int DW = 8
) (
  input  logic            sys_clk,
  input  logic            rst_n,
  input  logic [1:0]      mode,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [3*DW-1:0] s_data,
  input  logic [2:0]      s_user,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [3*DW-1:0] m_data,
  output logic [2:0]      m_user
);

  localparam int COEF_W = 9;
  localparam int PW     = DW + 9;
  localparam int SW     = DW + 11;
  localparam logic signed [SW-1:0] RND  = SW'(128);
  localparam logic signed [SW-1:0] MAXV = SW'((1 << DW) - 1);

  localparam logic signed [COEF_W-1:0] C601 [9] = '{
    9'sd77, 9'sd150, 9'sd29, -9'sd43, -9'sd85, 9'sd128, 9'sd128, -9'sd107, -9'sd21};
  localparam logic signed [COEF_W-1:0] C709 [9] = '{
    9'sd54, 9'sd183, 9'sd19, -9'sd29, -9'sd99, 9'sd128, 9'sd128, -9'sd116, -9'sd12};
  localparam logic signed [COEF_W-1:0] C601L [9] = '{
    9'sd66, 9'sd129, 9'sd25, -9'sd38, -9'sd74, 9'sd112, 9'sd112, -9'sd94, -9'sd18};

  function automatic logic signed [COEF_W-1:0] coef(input logic [1:0] md, input int idx);
    logic signed [COEF_W-1:0] c;
    case (md)
      2'd1:    c = C709[idx];
      2'd2:    c = C601L[idx];
      default: c = C601[idx];
    endcase
    return c;
  endfunction

  function automatic logic signed [PW-1:0] mul(input logic signed [DW:0] a,
                                               input logic signed [COEF_W-1:0] c);
    logic signed [PW-1:0] aa;
    logic signed [PW-1:0] cc;
    aa = PW'(a);
    cc = PW'(c);
    return aa * cc;
  endfunction

  function automatic logic signed [SW-1:0] offset(input logic [1:0] md, input int k);
    logic signed [SW-1:0] o;
    o = '0;
    if (k != 0)
      o = SW'(128) << DW;
    else if (md == 2'd2)
      o = SW'(16) << DW;
    return o;
  endfunction

  function automatic logic [DW-1:0] clamp(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] sh;
    logic [DW-1:0] r;
    sh = s >>> 8;
    if (sh < 0)
      r = '0;
    else if (sh > MAXV)
      r = '1;
    else
      r = sh[DW-1:0];
    return r;
  endfunction

  logic                    en;
  logic                    take;
  logic [1:0]              mode_act;
  logic [1:0]              beat_mode;
  logic signed [DW:0]      comp [3];

  logic                    vld_p0, vld_p1;
  logic signed [PW-1:0]    prod_p0 [9];
  logic [1:0]              mode_p0, mode_p1;
  logic [3*DW-1:0]         raw_p0, raw_p1;
  logic [2:0]              user_p0, user_p1;
  logic signed [SW-1:0]    sum_p1 [3];

  assign en      = !m_valid || m_ready;
  assign s_ready = en;

`ifdef CSC_FRAME_LOCK_EN
  logic vs_prev;
  assign take = s_user[2] && !vs_prev;
  always_ff @(posedge sys_clk) begin
    if (!rst_n)
      vs_prev <= 1'b0;
    else if (s_valid && en)
      vs_prev <= s_user[2];
  end
`else
  assign take = 1'b1;
`endif

  assign beat_mode = take ? mode : mode_act;

  always_ff @(posedge sys_clk) begin
    if (!rst_n)
      mode_act <= 2'd0;
    else if (s_valid && en && take)
      mode_act <= mode;
  end

  always_comb begin
    for (int k = 0; k < 3; k++)
      comp[k] = {1'b0, s_data[(2-k)*DW +: DW]};
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else if (en) begin
      vld_p0 <= s_valid;
      vld_p1 <= vld_p0;
    end
  end

  // S1: nine coefficient products, beat mode and sideband captured together
  always_ff @(posedge sys_clk) begin
    if (en) begin
      for (int i = 0; i < 9; i++)
        prod_p0[i] <= mul(comp[i % 3], coef(beat_mode, i));
      mode_p0 <= beat_mode;
      raw_p0  <= s_data;
      user_p0 <= s_user;
    end
  end

  // S2: per-channel sum with offset and rounding constant
  always_ff @(posedge sys_clk) begin
    if (en) begin
      for (int k = 0; k < 3; k++)
        sum_p1[k] <= SW'(prod_p0[3*k]) + SW'(prod_p0[3*k+1]) + SW'(prod_p0[3*k+2])
                     + offset(mode_p0, k) + RND;
      mode_p1 <= mode_p0;
      raw_p1  <= raw_p0;
      user_p1 <= user_p0;
    end
  end

  // S3: shift, clamp, bypass/blanking select into the output register
  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_user  <= '0;
    end else if (en) begin
      m_valid <= vld_p1;
      m_user  <= user_p1;
      if (!user_p1[0])
        m_data <= '0;
      else if (mode_p1 == 2'd3)
        m_data <= raw_p1;
      else
        m_data <= {clamp(sum_p1[0]), clamp(sum_p1[1]), clamp(sum_p1[2])};
    end
  end

endmodule

// File: tb/tb_csc_rgb2ycbcr_pipe.sv
// Self-checking bench for csc_rgb2ycbcr_pipe (DW = 8): scoreboard model plus directed literal vectors.
module tb_csc_rgb2ycbcr_pipe;
  localparam int DW = 8;

  logic            sys_clk = 1'b0;
  logic            rst_n   = 1'b0;
  logic [1:0]      mode    = 2'd0;
  logic            s_valid = 1'b0;
  logic            s_ready;
  logic [3*DW-1:0] s_data  = '0;
  logic [2:0]      s_user  = '0;
  logic            m_valid;
  logic            m_ready = 1'b1;
  logic [3*DW-1:0] m_data;
  logic [2:0]      m_user;

  csc_rgb2ycbcr_pipe #(.DW(DW)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .mode(mode),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_user(s_user),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_user(m_user)
  );

  always #5 sys_clk = ~sys_clk;

  int tests = 0;
  int fails = 0;
  int n_in  = 0;
  int n_out = 0;

  typedef struct { logic [23:0] d; logic [2:0] u; } beat_t;
  beat_t exp_q[$];

`ifdef CSC_FRAME_LOCK_EN
  int act_mode = 0;
  bit prev_vs  = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference conversion in plain integer arithmetic.
  function automatic logic [23:0] model(input logic [23:0] px, input int md, input bit de);
    int cf [3][9];
    int rgb [3];
    int v;
    logic [23:0] r;
    cf = '{'{77, 150, 29, -43, -85, 128, 128, -107, -21},
           '{54, 183, 19, -29, -99, 128, 128, -116, -12},
           '{66, 129, 25, -38, -74, 112, 112, -94, -18}};
    r = '0;
    if (!de) return r;
    if (md == 3) return px;
    rgb[0] = int'(px[23:16]);
    rgb[1] = int'(px[15:8]);
    rgb[2] = int'(px[7:0]);
    for (int k = 0; k < 3; k++) begin
      v = cf[md][3*k]*rgb[0] + cf[md][3*k+1]*rgb[1] + cf[md][3*k+2]*rgb[2];
      v = v + ((k == 0) ? ((md == 2) ? 16 : 0) : 128) * 256 + 128;
      v = v >>> 8;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      r[(2-k)*8 +: 8] = v[7:0];
    end
    return r;
  endfunction

  always @(negedge sys_clk) begin
    beat_t b;
    int md;
    if (!rst_n) begin
      exp_q.delete();
`ifdef CSC_FRAME_LOCK_EN
      act_mode = 0;
      prev_vs  = 1'b0;
`endif
    end else begin
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {29'd0, m_user}, 32'hFFFF_FFFF);
        end else begin
          chk("sb_data", {8'd0, m_data}, {8'd0, exp_q[0].d});
          chk("sb_user", {29'd0, m_user}, {29'd0, exp_q[0].u});
          if (m_ready) begin
            void'(exp_q.pop_front());
            n_out++;
          end
        end
        if (!m_ready) chk("stall_s_ready", {31'd0, s_ready}, 32'd0);
      end else begin
        chk("idle_s_ready", {31'd0, s_ready}, 32'd1);
      end
      if (s_valid && s_ready) begin
        md = int'(mode);
`ifdef CSC_FRAME_LOCK_EN
        if (s_user[2] && !prev_vs) act_mode = md;
        md = act_mode;
        prev_vs = s_user[2];
`endif
        b.d = model(s_data, md, s_user[0]);
        b.u = s_user;
        exp_q.push_back(b);
        n_in++;
      end
    end
  end

  task automatic send1(input logic [23:0] px, input logic [1:0] md, input logic [2:0] u,
                       output logic [23:0] d, output logic [2:0] uo, output int lat);
    @(posedge sys_clk); #1;
    s_data = px; mode = md; s_user = u; s_valid = 1'b1; m_ready = 1'b1;
    @(posedge sys_clk); #1;
    s_valid = 1'b0;
    lat = 1;
    while (!m_valid && lat < 10) begin
      @(posedge sys_clk); #1;
      lat++;
    end
    d  = m_data;
    uo = m_user;
  endtask

  function automatic logic [23:0] ramp(input int i);
    logic [7:0] r, g, b;
    r = 8'(i * 13);
    g = 8'(i * 7 + 3);
    b = 8'(255 - i * 11);
    return {r, g, b};
  endfunction

  initial begin
    logic [23:0] d;
    logic [2:0]  uo;
    int lat;
    int idx;
    bit acc;

    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {8'd0, m_data}, 32'd0);
    chk("rst_m_user", {29'd0, m_user}, 32'd0);
    rst_n = 1'b1;
    @(posedge sys_clk); #1;
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);

    send1(24'hFFFFFF, 2'd0, 3'b011, d, uo, lat);
    chk("white601_lat", lat, 3);
    chk("white601", {8'd0, d}, 32'h00FF8080);
    @(posedge sys_clk); #1;
    chk("bubble_after_last", {31'd0, m_valid}, 32'd0);

    send1(24'hFF0000, 2'd0, 3'b011, d, uo, lat);
    chk("red601", {8'd0, d}, 32'h004D55FF);

    send1(24'h000000, 2'd2, 3'b001, d, uo, lat);
    chk("black601l", {8'd0, d}, 32'h00108080);
    send1(24'hFFFFFF, 2'd2, 3'b001, d, uo, lat);
    chk("white601l", {8'd0, d}, 32'h00EB8080);

    send1(24'h123456, 2'd3, 3'b011, d, uo, lat);
    chk("bypass_lat", lat, 3);
    chk("bypass", {8'd0, d}, 32'h00123456);
    send1(24'h123456, 2'd3, 3'b110, d, uo, lat);
    chk("blank_data", {8'd0, d}, 32'd0);
    chk("blank_user", {29'd0, uo}, 32'd6);

    // Ramp with a 5-cycle downstream stall in the middle.
    idx = 0;
    for (int cyc = 0; cyc < 60 && idx < 20; cyc++) begin
      s_valid = 1'b1;
      s_data  = ramp(idx);
      mode    = 2'(idx % 4);
      s_user  = {idx % 5 == 0, 1'b1, idx % 6 != 5};
      m_ready = !(cyc >= 6 && cyc < 11);
      @(negedge sys_clk);
      acc = s_ready;
      if (cyc == 8) chk("ramp_stall_s_ready", {31'd0, s_ready}, 32'd0);
      @(posedge sys_clk); #1;
      if (acc) idx++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    chk("ramp_all_accepted", idx, 20);
    repeat (6) @(posedge sys_clk);
    #1;
    chk("ramp_drained", exp_q.size(), 0);
    chk("ramp_in_out", n_out, n_in);

    // Reset in the middle of a stream discards in-flight beats.
    s_data = 24'hA0B0C0; mode = 2'd0; s_user = 3'b011; s_valid = 1'b1;
    repeat (2) @(posedge sys_clk);
    #1;
    rst_n = 1'b0;
    @(posedge sys_clk); #1;
    chk("midrst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("midrst_m_data", {8'd0, m_data}, 32'd0);
    chk("midrst_m_user", {29'd0, m_user}, 32'd0);
    s_valid = 1'b0;
    rst_n = 1'b1;
    repeat (4) @(posedge sys_clk);
    #1;
    chk("midrst_no_ghost", {31'd0, m_valid}, 32'd0);

`ifdef CSC_FRAME_LOCK_EN
    send1(24'hFFFFFF, 2'd0, 3'b001, d, uo, lat);
    send1(24'hFFFFFF, 2'd0, 3'b101, d, uo, lat);
    chk("lock_frame_start_white", {24'd0, d[23:16]}, 32'd255);
    send1(24'hFF0000, 2'd1, 3'b001, d, uo, lat);
    chk("lock_midframe_red0", {24'd0, d[23:16]}, 32'd77);
    send1(24'hFF0000, 2'd1, 3'b001, d, uo, lat);
    chk("lock_midframe_red1", {24'd0, d[23:16]}, 32'd77);
    send1(24'hFF0000, 2'd1, 3'b101, d, uo, lat);
    chk("lock_new_frame_red", {24'd0, d[23:16]}, 32'd54);
`endif

    repeat (3) @(posedge sys_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
